// File: rtl/frame_bank_sched.sv
// frame_bank_sched
//   Picks the bank the camera writes and the bank the reader scans in a
//   RAM split into NUM_BANKS (2 or 3) frame-sized banks. The reader never
//   sees a partially written frame and always takes the newest complete one.
//
// Ports
//   clk_50      system clock, rising edge
//   reset       synchronous, active-high
//   wr_sof      pulse: camera start of frame
//   wr_eof      pulse: camera frame complete
//   wr_abort    pulse: discard current camera frame
//   rd_sof      pulse: reader starting a new scan
//   wr_bank     bank the camera writes
//   wr_active   camera write-enable gate
//   rd_bank     bank the reader scans
//   rd_valid    a complete frame has reached the reader since reset
//   rd_new      1-cycle pulse: last rd_sof switched to a fresh frame
//   frame_cnt   completed frames (wrapping)
//   drop_cnt    completed frames never shown (saturating)
//   repeat_cnt  rd_sof events with no fresh frame (saturating)
//
// Build option
//   FRAME_BANK_STATS_EN  when defined, drop_cnt/repeat_cnt are counted;
//                        otherwise those ports are tied to zero.
module frame_bank_sched #(
  parameter int NUM_BANKS = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             wr_sof,
  input  logic             wr_eof,
  input  logic             wr_abort,
  input  logic             rd_sof,
  output logic [1:0]       wr_bank,
  output logic             wr_active,
  output logic [1:0]       rd_bank,
  output logic             rd_valid,
  output logic             rd_new,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  typedef enum logic {W_IDLE, W_ACTIVE} wstate_e;

  wstate_e          st_q, st_d;
  logic [1:0]       wr_bank_q, wr_bank_d;
  logic [1:0]       rd_bank_q, rd_bank_d;
  logic [1:0]       rdy_bank_q, rdy_bank_d;
  logic             rdy_valid_q, rdy_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_new_q, rd_new_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

`ifdef FRAME_BANK_STATS_EN
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] repeat_q, repeat_d;
  logic [1:0]       drop_inc;
  logic             repeat_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
`endif

  // Events are applied in order abort/eof, rd_sof, wr_sof; each step works
  // on the *_d values left by the step before it.
  always_comb begin
    st_d        = st_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rdy_bank_d  = rdy_bank_q;
    rdy_valid_d = rdy_valid_q;
    rd_valid_d  = rd_valid_q;
    rd_new_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
`ifdef FRAME_BANK_STATS_EN
    drop_inc    = 2'd0;
    repeat_inc  = 1'b0;
`endif

    if (st_q == W_ACTIVE) begin
      if (wr_abort) begin
        st_d = W_IDLE;
      end else if (wr_eof) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
`ifdef FRAME_BANK_STATS_EN
        if (rdy_valid_q) drop_inc = drop_inc + 2'd1;
`endif
        rdy_bank_d  = wr_bank_q;
        rdy_valid_d = 1'b1;
        st_d        = W_IDLE;
      end
    end

    if (rd_sof) begin
      if (rdy_valid_d) begin
        rd_bank_d   = rdy_bank_d;
        rdy_valid_d = 1'b0;
        rd_valid_d  = 1'b1;
        rd_new_d    = 1'b1;
      end else begin
`ifdef FRAME_BANK_STATS_EN
        if (rd_valid_q) repeat_inc = 1'b1;
`endif
      end
    end

    if (wr_sof) begin
      st_d = W_ACTIVE;
      if (NUM_BANKS == 2) begin
        wr_bank_d = (rd_bank_d == 2'd0) ? 2'd1 : 2'd0;
        // Only two banks: a waiting frame in the write bank gets overwritten.
        if (rdy_valid_d && (rdy_bank_d == wr_bank_d)) begin
          rdy_valid_d = 1'b0;
`ifdef FRAME_BANK_STATS_EN
          drop_inc = drop_inc + 2'd1;
`endif
        end
      end else begin
        // Lowest bank held neither by the reader nor by a waiting frame.
        if ((rd_bank_d != 2'd0) && !(rdy_valid_d && (rdy_bank_d == 2'd0)))
          wr_bank_d = 2'd0;
        else if ((rd_bank_d != 2'd1) && !(rdy_valid_d && (rdy_bank_d == 2'd1)))
          wr_bank_d = 2'd1;
        else
          wr_bank_d = 2'd2;
      end
    end

`ifdef FRAME_BANK_STATS_EN
    drop_d   = sat_add(drop_q, drop_inc);
    repeat_d = sat_add(repeat_q, {1'b0, repeat_inc});
`endif
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      st_q        <= W_IDLE;
      wr_bank_q   <= 2'd1;
      rd_bank_q   <= 2'd0;
      rdy_bank_q  <= 2'd0;
      rdy_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_new_q    <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FRAME_BANK_STATS_EN
      drop_q      <= '0;
      repeat_q    <= '0;
`endif
    end else begin
      st_q        <= st_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rdy_bank_q  <= rdy_bank_d;
      rdy_valid_q <= rdy_valid_d;
      rd_valid_q  <= rd_valid_d;
      rd_new_q    <= rd_new_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_BANK_STATS_EN
      drop_q      <= drop_d;
      repeat_q    <= repeat_d;
`endif
    end
  end

  assign wr_bank   = wr_bank_q;
  assign wr_active = (st_q == W_ACTIVE);
  assign rd_bank   = rd_bank_q;
  assign rd_valid  = rd_valid_q;
  assign rd_new    = rd_new_q;
  assign frame_cnt = frame_cnt_q;
`ifdef FRAME_BANK_STATS_EN
  assign drop_cnt   = drop_q;
  assign repeat_cnt = repeat_q;
`else
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_bank_sched.sv
// Directed bench for frame_bank_sched: a triple-buffer instance (CNT_W=16)
// and a double-buffer instance with narrow counters (CNT_W=3) so that
// wrap and saturation are reachable in a few cycles.
module tb_frame_bank_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // triple-buffer instance
  logic        a_reset, a_wr_sof, a_wr_eof, a_wr_abort, a_rd_sof;
  logic [1:0]  a_wr_bank, a_rd_bank;
  logic        a_wr_active, a_rd_valid, a_rd_new;
  logic [15:0] a_frame_cnt, a_drop_cnt, a_repeat_cnt;

  // double-buffer instance
  logic        b_reset, b_wr_sof, b_wr_eof, b_wr_abort, b_rd_sof;
  logic [1:0]  b_wr_bank, b_rd_bank;
  logic        b_wr_active, b_rd_valid, b_rd_new;
  logic [2:0]  b_frame_cnt, b_drop_cnt, b_repeat_cnt;

  frame_bank_sched #(.NUM_BANKS(3), .CNT_W(16)) u3 (
    .clk_50(clk), .reset(a_reset), .wr_sof(a_wr_sof), .wr_eof(a_wr_eof),
    .wr_abort(a_wr_abort), .rd_sof(a_rd_sof), .wr_bank(a_wr_bank),
    .wr_active(a_wr_active), .rd_bank(a_rd_bank), .rd_valid(a_rd_valid),
    .rd_new(a_rd_new), .frame_cnt(a_frame_cnt), .drop_cnt(a_drop_cnt),
    .repeat_cnt(a_repeat_cnt));

  frame_bank_sched #(.NUM_BANKS(2), .CNT_W(3)) u2 (
    .clk_50(clk), .reset(b_reset), .wr_sof(b_wr_sof), .wr_eof(b_wr_eof),
    .wr_abort(b_wr_abort), .rd_sof(b_rd_sof), .wr_bank(b_wr_bank),
    .wr_active(b_wr_active), .rd_bank(b_rd_bank), .rd_valid(b_rd_valid),
    .rd_new(b_rd_new), .frame_cnt(b_frame_cnt), .drop_cnt(b_drop_cnt),
    .repeat_cnt(b_repeat_cnt));

  // Statistics counters read as zero when the option is not built in.
  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef FRAME_BANK_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses; outputs are sampled 1 time unit later.
  task automatic a_cyc(input logic sof, input logic eof, input logic ab, input logic rs);
    a_wr_sof = sof; a_wr_eof = eof; a_wr_abort = ab; a_rd_sof = rs;
    @(posedge clk); #1;
    a_wr_sof = 0; a_wr_eof = 0; a_wr_abort = 0; a_rd_sof = 0;
  endtask

  task automatic b_cyc(input logic sof, input logic eof, input logic ab, input logic rs);
    b_wr_sof = sof; b_wr_eof = eof; b_wr_abort = ab; b_rd_sof = rs;
    @(posedge clk); #1;
    b_wr_sof = 0; b_wr_eof = 0; b_wr_abort = 0; b_rd_sof = 0;
  endtask

  initial begin
    a_reset = 1; a_wr_sof = 0; a_wr_eof = 0; a_wr_abort = 0; a_rd_sof = 0;
    b_reset = 1; b_wr_sof = 0; b_wr_eof = 0; b_wr_abort = 0; b_rd_sof = 0;
    @(posedge clk); @(posedge clk); #1;
    a_reset = 0; b_reset = 0;

    // ---- triple buffer: reset state
    check("rst_rd_bank",   a_rd_bank, 0);
    check("rst_wr_bank",   a_wr_bank, 1);
    check("rst_wr_active", a_wr_active, 0);
    check("rst_rd_valid",  a_rd_valid, 0);
    check("rst_rd_new",    a_rd_new, 0);
    check("rst_frame",     a_frame_cnt, 0);
    check("rst_drop",      a_drop_cnt, 0);
    check("rst_repeat",    a_repeat_cnt, 0);

    // rd_sof before any frame
    a_cyc(0, 0, 0, 1);
    check("early_rd_bank", a_rd_bank, 0);
    check("early_rd_valid", a_rd_valid, 0);
    check("early_rd_new",  a_rd_new, 0);
    check("early_repeat",  a_repeat_cnt, 0);

    // wr_eof while idle is ignored
    a_cyc(0, 1, 0, 0);
    check("idle_eof_frame", a_frame_cnt, 0);

    // single frame delivered
    a_cyc(1, 0, 0, 0);
    check("f1_wr_bank", a_wr_bank, 1);
    check("f1_active",  a_wr_active, 1);
    a_cyc(0, 0, 0, 0);
    check("f1_active_hold", a_wr_active, 1);
    a_cyc(0, 1, 0, 0);
    check("f1_frame", a_frame_cnt, 1);
    check("f1_inactive", a_wr_active, 0);
    check("f1_rd_bank_before", a_rd_bank, 0);
    a_cyc(0, 0, 0, 1);
    check("f1_rd_bank", a_rd_bank, 1);
    check("f1_rd_new",  a_rd_new, 1);
    check("f1_rd_valid", a_rd_valid, 1);
    a_cyc(0, 0, 0, 0);
    check("f1_rd_new_drop", a_rd_new, 0);

    // three frames with no reader switch
    a_reset = 1; a_cyc(0, 0, 0, 0); a_reset = 0;
    check("r2_rd_valid", a_rd_valid, 0);
    check("r2_frame", a_frame_cnt, 0);
    a_cyc(1, 0, 0, 0); check("t1_wr_bank", a_wr_bank, 1);
    a_cyc(0, 1, 0, 0); check("t1_frame", a_frame_cnt, 1); check("t1_drop", a_drop_cnt, st(0));
    a_cyc(1, 0, 0, 0); check("t2_wr_bank", a_wr_bank, 2);
    a_cyc(0, 1, 0, 0); check("t2_frame", a_frame_cnt, 2); check("t2_drop", a_drop_cnt, st(1));
    a_cyc(1, 0, 0, 0); check("t3_wr_bank", a_wr_bank, 1);
    a_cyc(0, 1, 0, 0); check("t3_frame", a_frame_cnt, 3); check("t3_drop", a_drop_cnt, st(2));
    a_cyc(0, 0, 0, 1);
    check("t3_rd_bank", a_rd_bank, 1);
    check("t3_rd_new", a_rd_new, 1);

    // wr_eof and rd_sof in the same cycle, then wr_sof
    a_cyc(1, 0, 0, 0); check("same_wr_bank", a_wr_bank, 0);
    a_cyc(0, 1, 0, 1);
    check("same_rd_bank", a_rd_bank, 0);
    check("same_rd_new", a_rd_new, 1);
    check("same_frame", a_frame_cnt, 4);
    check("same_drop", a_drop_cnt, st(2));
    a_cyc(1, 0, 0, 0);
    check("same_next_wr_bank", a_wr_bank, 1);
    check("same_next_rd_new", a_rd_new, 0);
    check("same_next_drop", a_drop_cnt, st(2));

    // abort mid-frame
    a_cyc(0, 0, 1, 0);
    check("abort_inactive", a_wr_active, 0);
    check("abort_frame", a_frame_cnt, 4);
    a_cyc(0, 0, 0, 1);
    check("abort_rd_bank", a_rd_bank, 0);
    check("abort_rd_new", a_rd_new, 0);
    check("abort_repeat", a_repeat_cnt, st(1));

    // abort and eof together: abort wins
    a_cyc(1, 0, 0, 0);
    a_cyc(0, 1, 1, 0);
    check("abeof_inactive", a_wr_active, 0);
    check("abeof_frame", a_frame_cnt, 4);
    a_cyc(0, 0, 0, 1);
    check("abeof_repeat", a_repeat_cnt, st(2));
    check("abeof_rd_bank", a_rd_bank, 0);

    // back-to-back wr_sof, then reset while active
    a_cyc(1, 0, 0, 0);
    a_cyc(1, 0, 0, 0);
    check("b2b_active", a_wr_active, 1);
    check("b2b_wr_bank", a_wr_bank, 1);
    a_reset = 1; a_cyc(0, 0, 0, 0); a_reset = 0;
    check("mid_rst_active", a_wr_active, 0);
    check("mid_rst_wr_bank", a_wr_bank, 1);
    check("mid_rst_rd_bank", a_rd_bank, 0);
    check("mid_rst_rd_valid", a_rd_valid, 0);
    check("mid_rst_rd_new", a_rd_new, 0);
    check("mid_rst_frame", a_frame_cnt, 0);
    check("mid_rst_drop", a_drop_cnt, 0);
    check("mid_rst_repeat", a_repeat_cnt, 0);
    a_cyc(0, 0, 0, 1);
    check("post_rst_rd_bank", a_rd_bank, 0);
    check("post_rst_rd_new", a_rd_new, 0);

    // ---- double buffer
    check("b_rst_rd_bank", b_rd_bank, 0);
    check("b_rst_wr_bank", b_wr_bank, 1);
    b_cyc(1, 0, 0, 0); check("b1_wr_bank", b_wr_bank, 1);
    b_cyc(0, 1, 0, 0); check("b1_frame", b_frame_cnt, 1);
    b_cyc(0, 0, 0, 1);
    check("b1_rd_bank", b_rd_bank, 1);
    check("b1_rd_new", b_rd_new, 1);
    check("b1_rd_valid", b_rd_valid, 1);
    b_cyc(1, 0, 0, 0); check("b2_wr_bank", b_wr_bank, 0); check("b2_drop", b_drop_cnt, st(0));
    b_cyc(0, 1, 0, 0); check("b2_frame", b_frame_cnt, 2);
    // wr_sof before rd_sof overwrites the ready frame
    b_cyc(1, 0, 0, 0);
    check("ovw_wr_bank", b_wr_bank, 0);
    check("ovw_active", b_wr_active, 1);
    check("ovw_drop", b_drop_cnt, st(1));
    b_cyc(0, 0, 1, 0);
    b_cyc(0, 0, 0, 1);
    check("ovw_rd_bank", b_rd_bank, 1);
    check("ovw_rd_new", b_rd_new, 0);
    check("ovw_repeat", b_repeat_cnt, st(1));

    // each eof+sof cycle completes a frame and overwrites it: wrap and saturate
    b_cyc(1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      b_cyc(1, 1, 0, 0);
      check($sformatf("wrap_frame_%0d", k), b_frame_cnt, (2 + k) % 8);
      check($sformatf("sat_drop_%0d", k), b_drop_cnt, st((k + 1 > 7) ? 7 : k + 1));
      check($sformatf("wrap_wr_bank_%0d", k), b_wr_bank, 0);
    end
    for (int k = 1; k <= 7; k++) begin
      b_cyc(0, 0, 0, 1);
      check($sformatf("sat_repeat_%0d", k), b_repeat_cnt, st((k + 1 > 7) ? 7 : k + 1));
      check($sformatf("sat_rd_bank_%0d", k), b_rd_bank, 1);
    end
    check("b_end_active", b_wr_active, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
